// File: rtl/sync_fifo_if.sv
// Handshake, data and status bundle shared by the FIFO and whatever drives it.
interface sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             clr;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  // Producer / register-stage side.
  modport master (
    output clr, wr_en, data_in, rd_en,
    input  data_out, full, empty, count, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  clr, wr_en, data_in, rd_en,
    output data_out, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with a registered read port, occupancy count,
// derived full/empty flags and sticky overflow/underflow error flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,      // asynchronous, active low
  sync_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;

  // Flags come straight from the registered count, so they are glitch-free.
  // A push into a full FIFO is fine when a pop frees a slot in the same cycle;
  // a pop from an empty FIFO is never fine, even alongside a push.
  always_comb begin
    full    = (count_reg == CNT_MAX);
    empty   = (count_reg == '0);
    push_ok = bus.wr_en & (~full | bus.rd_en);
    pop_ok  = bus.rd_en & ~empty;
  end

  // Storage array: written on accepted pushes only, no reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (!bus.clr && push_ok) begin
      mem[wr_ptr_reg] <= bus.data_in;
    end
  end

  // Pointers, count, registered read data and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      data_out_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (bus.clr) begin
      // Flush drops every entry but keeps the last word presented downstream.
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_ok) begin
        // Reads the pre-edge contents, so a full-FIFO pop+push to the same
        // slot still returns the oldest entry.
        data_out_reg <= mem[rd_ptr_reg];
        rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - CNT_ONE;
      end
      if (bus.wr_en && full && !bus.rd_en) begin
        overflow_reg <= 1'b1;
      end
      if (bus.rd_en && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  // Drive the status and data outputs from registered state only.
  always_comb begin
    bus.data_out  = data_out_reg;
    bus.full      = full;
    bus.empty     = empty;
    bus.count     = count_reg;
    bus.overflow  = overflow_reg;
    bus.underflow = underflow_reg;
  end
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_sync_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic clk;
  logic rst;

  sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of stored words plus the output/error state.
  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] model_dout;
  logic             model_ovf;
  logic             model_udf;

  task automatic model_reset();
    model_q.delete();
    model_dout = '0;
    model_ovf  = 1'b0;
    model_udf  = 1'b0;
  endtask

  // Drive one transaction at the current negedge, let the rising edge happen,
  // update the model with the same inputs, and return on the next negedge.
  task automatic cycle(input logic wr, input logic [WIDTH-1:0] din,
                       input logic rd, input logic clr);
    bus.wr_en   = wr;
    bus.data_in = din;
    bus.rd_en   = rd;
    bus.clr     = clr;
    @(posedge clk);
    if (clr) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_udf = 1'b0;
    end else begin
      int  sz;
      bit  do_pop;
      bit  do_push;
      sz      = model_q.size();
      do_pop  = rd && (sz > 0);
      do_push = wr && ((sz < DEPTH) || rd);
      if (wr && (sz == DEPTH) && !rd) model_ovf = 1'b1;
      if (rd && (sz == 0))            model_udf = 1'b1;
      if (do_pop)  model_dout = model_q.pop_front();
      if (do_push) model_q.push_back(din);
    end
    @(negedge clk);
    $display("txn t=%0t wr=%0b din=%02h rd=%0b clr=%0b -> dout=%02h cnt=%0d full=%0b empty=%0b ovf=%0b udf=%0b",
             $time, wr, din, rd, clr, bus.data_out, bus.count, bus.full, bus.empty,
             bus.overflow, bus.underflow);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%02h exp=00", bus.data_out); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++;
      $display("FAIL reset_err got=%0b%0b exp=00", bus.overflow, bus.underflow); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] pat [3];
    pat[0] = 8'h55; pat[1] = 8'hAA; pat[2] = 8'hFF;
    for (int i = 0; i < 3; i++) cycle(1'b1, pat[i], 1'b0, 1'b0);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL basic_count3 got=%0d exp=3", bus.count); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (bus.data_out !== pat[i]) begin errors++;
        $display("FAIL basic_pop%0d got=%02h exp=%02h", i, bus.data_out, pat[i]); end
      checks++; if (bus.count !== 3'(2 - i)) begin errors++;
        $display("FAIL basic_count_pop%0d got=%0d exp=%0d", i, bus.count, 2 - i); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL basic_empty got=%0b exp=1", bus.empty); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got=%0b exp=1", bus.full); end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%0b exp=1", bus.overflow); end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count_ovf got=%0d exp=4", bus.count); end
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (bus.data_out !== 8'(i)) begin errors++;
        $display("FAIL fill_pop%0d got=%02h exp=%02h", i, bus.data_out, 8'(i)); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fill_drain_empty got=%0b exp=1", bus.empty); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);  // flush to drop the sticky overflow
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] exp_word;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'h20 + 8'(i));
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
      exp_word = exp_q.pop_front();
      exp_q.push_back(8'h10 + 8'(i));
      checks++; if (bus.data_out !== exp_word) begin errors++;
        $display("FAIL wrap_pop%0d got=%02h exp=%02h", i, bus.data_out, exp_word); end
      checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1) begin errors++;
        $display("FAIL wrap_level%0d got cnt=%0d full=%0b exp cnt=4 full=1", i, bus.count, bus.full); end
    end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL wrap_no_ovf got=%0b exp=0", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      exp_word = exp_q.pop_front();
      checks++; if (bus.data_out !== exp_word) begin errors++;
        $display("FAIL wrap_drain%0d got=%02h exp=%02h", i, bus.data_out, exp_word); end
    end
  endtask

  task automatic test_empty();
    logic [WIDTH-1:0] held;
    held = bus.data_out;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL empty_underflow got=%0b exp=1", bus.underflow); end
    checks++; if (bus.data_out !== held) begin errors++;
      $display("FAIL empty_dout_held got=%02h exp=%02h", bus.data_out, held); end
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL empty_pushpop_count got=%0d exp=1", bus.count); end
    checks++; if (bus.data_out !== held) begin errors++;
      $display("FAIL empty_pushpop_dout got=%02h exp=%02h", bus.data_out, held); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.data_out !== 8'h77) begin errors++; $display("FAIL empty_pop77 got=%02h exp=77", bus.data_out); end
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL empty_udf_sticky got=%0b exp=1", bus.underflow); end
  endtask

  // Bring the FIFO to count=2 with overflow set and a non-zero data_out.
  task automatic setup_two_with_overflow();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_midreset();
    logic [WIDTH-1:0] held;
    setup_two_with_overflow();
    checks++; if (bus.count !== 3'd2 || bus.overflow !== 1'b1) begin errors++;
      $display("FAIL midrst_setup got cnt=%0d ovf=%0b exp cnt=2 ovf=1", bus.count, bus.overflow); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin errors++;
      $display("FAIL midrst_level got cnt=%0d empty=%0b exp cnt=0 empty=1", bus.count, bus.empty); end
    checks++; if (bus.data_out !== 8'h00 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++;
      $display("FAIL midrst_regs got dout=%02h ovf=%0b udf=%0b exp dout=00 ovf=0 udf=0",
               bus.data_out, bus.overflow, bus.underflow); end
    #1 rst = 1'b1;
    @(negedge clk);
    setup_two_with_overflow();
    held = bus.data_out;
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin errors++;
      $display("FAIL clr_level got cnt=%0d empty=%0b exp cnt=0 empty=1", bus.count, bus.empty); end
    checks++; if (bus.data_out !== held || bus.overflow !== 1'b0) begin errors++;
      $display("FAIL clr_regs got dout=%02h ovf=%0b exp dout=%02h ovf=0", bus.data_out, bus.overflow, held); end
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.data_out !== 8'h3C) begin errors++;
      $display("FAIL clr_restart got=%02h exp=3c", bus.data_out); end
  endtask

  task automatic test_random();
    logic wr, rd, clr;
    for (int n = 0; n < 300; n++) begin
      wr  = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 24) == 0);
      cycle(wr, 8'($urandom), rd, clr);
      checks++;
      if (bus.data_out !== model_dout || bus.count !== 3'(model_q.size()) ||
          bus.full !== (model_q.size() == DEPTH) || bus.empty !== (model_q.size() == 0) ||
          bus.overflow !== model_ovf || bus.underflow !== model_udf) begin
        errors++;
        $display("FAIL random%0d got dout=%02h cnt=%0d full=%0b empty=%0b ovf=%0b udf=%0b exp dout=%02h cnt=%0d ovf=%0b udf=%0b",
                 n, bus.data_out, bus.count, bus.full, bus.empty, bus.overflow, bus.underflow,
                 model_dout, model_q.size(), model_ovf, model_udf);
      end
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.clr     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    model_reset();
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_empty();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
